// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage and its IF/ID register.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,  // issue the first request after reset
        WAIT  = 2'd1,  // one request outstanding, its data is wanted
        DROP  = 2'd2,  // one request outstanding, its data is stale
        HOLD  = 2'd3   // response parked in the hold buffer during a stall
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    // Payload written into the IF/ID register when an instruction is delivered.
    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] pc_plus4;
    } if_id_t;

    // Redirect targets are word aligned before they become a fetch address.
    function automatic logic [63:0] align_pc(input logic [63:0] pc);
        return {pc[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a delivered instruction, hold on stall, bubble otherwise.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        stall,
    input  logic        flush,
    input  if_id_t      load_data,
    output logic [31:0] instr,
    output logic [63:0] pc,
    output logic [63:0] pc_plus4,
    output logic        valid
);

    logic [31:0] instr_q, instr_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;

    always_comb begin
        // NOTE: every variable gets a default before the priority chain so no path infers a latch.
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;

        // Flush beats load beats stall; an idle unstalled cycle inserts a bubble.
        if (flush) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (load) begin
            instr_d    = load_data.instr;
            pc_d       = load_data.pc;
            pc_plus4_d = load_data.pc_plus4;
            valid_d    = 1'b1;
        end else if (!stall) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr    = instr_q;
    assign pc       = pc_q;
    assign pc_plus4 = pc_plus4_q;
    assign valid    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: single-outstanding memory requests, redirect/stall handling, IF/ID feed.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [63:0] PCTargetE,
    output logic        ImemReq,
    output logic [63:0] ImemAddr,
    input  logic        ImemRvalid,
    input  logic [31:0] ImemRdata,
    output logic [31:0] InstrD,
    output logic [63:0] PCD,
    output logic [63:0] PCPlus4D,
    output logic        ValidD
);

    fetch_state_t state_q, state_d;
    logic [63:0]  pcf_q, pcf_d;
    logic [31:0]  hold_q, hold_d;

    logic         req;
    logic [63:0]  addr;
    logic         load;
    if_id_t       load_data;
    logic [63:0]  target;
    logic [63:0]  pc_plus4;

    assign target   = align_pc(PCTargetE);
    assign pc_plus4 = pcf_q + 64'd4;

    always_comb begin
        state_d   = state_q;
        pcf_d     = pcf_q;
        hold_d    = hold_q;
        req       = 1'b0;
        addr      = pcf_q;
        load      = 1'b0;
        load_data = '{instr: hold_q, pc: pcf_q, pc_plus4: pc_plus4};

        // PCF always names the address of the outstanding or buffered fetch.
        unique case (state_q)
            START: begin
                // Any response seen here belongs to a pre-reset request and is ignored.
                req     = 1'b1;
                addr    = PCSrcE ? target : pcf_q;
                pcf_d   = addr;
                state_d = WAIT;
            end
            WAIT: begin
                if (ImemRvalid) begin
                    if (PCSrcE) begin
                        req   = 1'b1;
                        addr  = target;
                        pcf_d = target;
                    end else if (StallF) begin
                        hold_d  = ImemRdata;
                        state_d = HOLD;
                    end else begin
                        load            = 1'b1;
                        load_data.instr = ImemRdata;
                        req             = 1'b1;
                        addr            = pc_plus4;
                        pcf_d           = pc_plus4;
                    end
                end else if (PCSrcE) begin
                    pcf_d   = target;
                    state_d = DROP;
                end
            end
            DROP: begin
                if (ImemRvalid) begin
                    req     = 1'b1;
                    addr    = PCSrcE ? target : pcf_q;
                    pcf_d   = addr;
                    state_d = WAIT;
                end else if (PCSrcE) begin
                    pcf_d = target;
                end
            end
            HOLD: begin
                if (PCSrcE) begin
                    hold_d  = '0;
                    req     = 1'b1;
                    addr    = target;
                    pcf_d   = target;
                    state_d = WAIT;
                end else if (!StallF) begin
                    load    = 1'b1;
                    req     = 1'b1;
                    addr    = pc_plus4;
                    pcf_d   = pc_plus4;
                    state_d = WAIT;
                end
            end
            default: state_d = START;
        endcase

        // No request may leave the block while reset is held.
        if (reset) begin
            req = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= START;
            pcf_q   <= RESET_PC;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pcf_q   <= pcf_d;
            hold_q  <= hold_d;
        end
    end

    assign ImemReq  = req;
    assign ImemAddr = addr;

    if_id_reg u_if_id (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .stall    (StallF),
        .flush    (FlushD),
        .load_data(load_data),
        .instr    (InstrD),
        .pc       (PCD),
        .pc_plus4 (PCPlus4D),
        .valid    (ValidD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized and directed bench for fetch_stage against a transaction-level fetch model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk;
    logic        reset;
    logic        StallF, FlushD, PCSrcE;
    logic [63:0] PCTargetE;
    logic        ImemReq;
    logic [63:0] ImemAddr;
    logic        ImemRvalid;
    logic [31:0] ImemRdata;
    logic [31:0] InstrD;
    logic [63:0] PCD, PCPlus4D;
    logic        ValidD;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .reset     (reset),
        .StallF    (StallF),
        .FlushD    (FlushD),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .ImemReq   (ImemReq),
        .ImemAddr  (ImemAddr),
        .ImemRvalid(ImemRvalid),
        .ImemRdata (ImemRdata),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    localparam logic [31:0] W0 = 32'h0050_0093;
    localparam logic [31:0] W1 = 32'h00A0_0113;
    localparam logic [31:0] W2 = 32'h0020_81B3;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h0:   return W0;
            64'h4:   return W1;
            64'h8:   return W2;
            default: return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
        endcase
    endfunction

    // Memory model: one pending response delivered lat cycles after its request.
    int          lat = 1;
    logic        pend = 1'b0;
    int          pend_cnt = 0;
    logic [63:0] pend_addr = '0;

    // Reference model: fetch bookkeeping as flags rather than an FSM encoding.
    logic        m_fresh = 1'b1;   // first request after reset not yet issued
    logic        m_out   = 1'b0;   // a request is outstanding
    logic        m_kill  = 1'b0;   // the outstanding response is on a dead path
    logic        m_buf_v = 1'b0;   // a response is parked awaiting end of stall
    logic [31:0] m_buf_d = '0;
    logic [63:0] m_pc    = RESET_PC;
    logic [31:0] m_instr = NOP_INSTR;
    logic [63:0] m_pcd   = '0;
    logic [63:0] m_pc4d  = '0;
    logic        m_valid = 1'b0;

    logic        obs_req;
    logic [63:0] obs_addr;

    task automatic step(input logic rst, input logic stall, input logic flush,
                        input logic pcsrc, input logic [63:0] tgt, input logic stray);
        logic        rv;
        logic [31:0] rd;
        logic        m_req;
        logic [63:0] m_addr;
        logic [63:0] tgt_al;
        logic        dlv;
        logic [31:0] d_instr;

        @(negedge clk);
        rv = 1'b0;
        rd = '0;
        if (rst) begin
            pend = 1'b0;
        end else if (pend) begin
            if (pend_cnt == 1) begin
                rv   = 1'b1;
                rd   = mem_word(pend_addr);
                pend = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        if (stray) begin
            rv = 1'b1;
            rd = 32'hDEAD_BEEF;
        end
        reset      = rst;
        StallF     = stall;
        FlushD     = flush;
        PCSrcE     = pcsrc;
        PCTargetE  = tgt;
        ImemRvalid = rv;
        ImemRdata  = rd;
        #1;
        obs_req  = ImemReq;
        obs_addr = ImemAddr;

        m_req   = 1'b0;
        m_addr  = '0;
        dlv     = 1'b0;
        d_instr = '0;
        tgt_al  = tgt & ~64'h3;
        if (!rst) begin
            if (m_fresh) begin
                m_req  = 1'b1;
                m_addr = pcsrc ? tgt_al : m_pc;
            end else if (m_buf_v) begin
                if (pcsrc) begin
                    m_buf_v = 1'b0;
                    m_req   = 1'b1;
                    m_addr  = tgt_al;
                end else if (!stall) begin
                    dlv     = 1'b1;
                    d_instr = m_buf_d;
                    m_buf_v = 1'b0;
                    m_req   = 1'b1;
                    m_addr  = m_pc + 64'd4;
                end
            end else if (m_out && rv) begin
                if (m_kill || pcsrc) begin
                    m_req  = 1'b1;
                    m_addr = pcsrc ? tgt_al : m_pc;
                end else if (stall) begin
                    m_buf_v = 1'b1;
                    m_buf_d = rd;
                    m_out   = 1'b0;
                end else begin
                    dlv     = 1'b1;
                    d_instr = rd;
                    m_req   = 1'b1;
                    m_addr  = m_pc + 64'd4;
                end
            end else if (m_out && pcsrc) begin
                m_pc   = tgt_al;
                m_kill = 1'b1;
            end
        end

        check("imem_req", 64'(ImemReq), 64'(m_req));
        if (m_req && ImemReq) check("imem_addr", ImemAddr, m_addr);
        check("one_outstanding", 64'(pend & ImemReq), 64'd0);
        if (ImemReq) begin
            pend      = 1'b1;
            pend_cnt  = lat;
            pend_addr = ImemAddr;
        end

        if (rst) begin
            m_fresh = 1'b1;
            m_out   = 1'b0;
            m_kill  = 1'b0;
            m_buf_v = 1'b0;
            m_pc    = RESET_PC;
            m_instr = NOP_INSTR;
            m_pcd   = '0;
            m_pc4d  = '0;
            m_valid = 1'b0;
        end else begin
            if (flush) begin
                m_instr = NOP_INSTR;
                m_valid = 1'b0;
            end else if (dlv) begin
                m_instr = d_instr;
                m_pcd   = m_pc;
                m_pc4d  = m_pc + 64'd4;
                m_valid = 1'b1;
            end else if (!stall) begin
                m_instr = NOP_INSTR;
                m_valid = 1'b0;
            end
            if (m_req) begin
                m_fresh = 1'b0;
                m_out   = 1'b1;
                m_kill  = 1'b0;
                m_pc    = m_addr;
            end
        end

        @(posedge clk);
        #1;
        check("instr_d", 64'(InstrD), 64'(m_instr));
        check("valid_d", 64'(ValidD), 64'(m_valid));
        if (m_valid || rst) begin
            check("pc_d", PCD, m_pcd);
            check("pc_plus4_d", PCPlus4D, m_pc4d);
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int reqs;
        int valids;
        logic [63:0] tgt;

        reset = 1'b1; StallF = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        PCTargetE = '0; ImemRvalid = 1'b0; ImemRdata = '0;

        // Reset state and back-to-back fetch with a 1-cycle memory.
        lat = 1;
        do_reset();
        check("rst_instr", 64'(InstrD), 64'(NOP_INSTR));
        check("rst_valid", 64'(ValidD), 64'd0);
        idle();
        check("seq_addr0", obs_addr, 64'h0);
        idle();
        check("seq_addr4", obs_addr, 64'h4);
        check("seq_instr0", 64'(InstrD), 64'(W0));
        idle();
        check("seq_addr8", obs_addr, 64'h8);
        check("seq_instr1", 64'(InstrD), 64'(W1));
        idle();
        check("seq_instr2", 64'(InstrD), 64'(W2));
        check("seq_valid2", 64'(ValidD), 64'd1);

        // 3-cycle memory: one request and one valid instruction per three cycles.
        lat = 3;
        do_reset();
        idle();
        reqs = 0;
        valids = 0;
        for (int i = 0; i < 9; i++) begin
            idle();
            reqs   += int'(obs_req);
            valids += int'(ValidD);
        end
        check("lat3_reqs", 64'(reqs), 64'd3);
        check("lat3_valids", 64'(valids), 64'd3);

        // Redirect while the request for 0x8 is outstanding.
        lat = 2;
        do_reset();
        for (int i = 0; i < 5; i++) idle();
        step(1'b0, 1'b0, 1'b0, 1'b1, 64'h100, 1'b0);
        idle();
        check("redir_addr", obs_addr, 64'h100);
        check("redir_drop_valid", 64'(ValidD), 64'd0);
        idle();
        idle();
        check("redir_pcd", PCD, 64'h100);
        check("redir_instr", 64'(InstrD), 64'(mem_word(64'h100)));

        // Stall for three cycles while the word at 0x4 returns.
        lat = 1;
        do_reset();
        idle();
        idle();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
            check("stall_instr", 64'(InstrD), 64'(W0));
            check("stall_pcd", PCD, 64'h0);
        end
        idle();
        check("unstall_instr", 64'(InstrD), 64'(W1));
        check("unstall_pcd", PCD, 64'h4);
        idle();
        check("unstall_next", 64'(InstrD), 64'(W2));

        // Flush coinciding with a delivery still advances the PC.
        do_reset();
        idle();
        step(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
        check("flush_instr", 64'(InstrD), 64'(NOP_INSTR));
        check("flush_valid", 64'(ValidD), 64'd0);
        check("flush_addr", obs_addr, 64'h4);
        idle();
        check("flush_next_pcd", PCD, 64'h4);

        // Unaligned redirect near the top of memory, then wrap to zero.
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        check("wrap_align", obs_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        idle();
        check("wrap_addr", obs_addr, 64'h0);
        check("wrap_pcd", PCD, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_pc4d", PCPlus4D, 64'h0);

        // Reset with a response pending, plus a stray late response in START.
        lat = 3;
        do_reset();
        idle();
        idle();
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        check("rstmid_req", 64'(obs_req), 64'd1);
        check("rstmid_addr", obs_addr, RESET_PC);
        check("rstmid_valid0", 64'(ValidD), 64'd0);
        idle();
        idle();
        check("rstmid_valid1", 64'(ValidD), 64'd0);
        idle();
        check("rstmid_first", 64'(InstrD), 64'(W0));

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 0) lat = int'($urandom_range(1, 4));
            tgt = ($urandom_range(0, 1) == 1) ? 64'($urandom_range(0, 255)) : {$urandom, $urandom};
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, tgt, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
